// File: rtl/fwd_pkg.sv
// fwd_pkg: select-encoding helpers shared by the forwarding operand register and its selector.
package fwd_pkg;

   // Select code that means "operand came from the register file".
   function automatic int sel_rf(input int nsrc);
      return nsrc;
   endfunction

   // Width needed to encode sources 0..nsrc-1 plus the register-file code.
   function automatic int sel_w(input int nsrc);
      return $clog2(nsrc + 1);
   endfunction

endpackage

// File: rtl/fwd_prio_sel.sv
// fwd_prio_sel: combinational fixed-priority forwarding selector (lowest source index wins).
// Ports:
//   addr_i     - register address being looked up
//   rf_data_i  - register-file value used when no source matches
//   src_we_i   - per-source write enable
//   src_addr_i - per-source destination address, source i at [i*AW +: AW]
//   src_data_i - per-source result, source i at [i*WIDTH +: WIDTH]
//   data_o     - selected operand value
//   sel_o      - winning source index, or NSRC for the register file
//   hit_o      - a forwarding source was selected
module fwd_prio_sel
   import fwd_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int AW = 5,
   parameter int NSRC = 3,
   localparam int SELW = sel_w(NSRC)
) (
   input  logic [AW-1:0]         addr_i,
   input  logic [WIDTH-1:0]      rf_data_i,
   input  logic [NSRC-1:0]       src_we_i,
   input  logic [NSRC*AW-1:0]    src_addr_i,
   input  logic [NSRC*WIDTH-1:0] src_data_i,
   output logic [WIDTH-1:0]      data_o,
   output logic [SELW-1:0]       sel_o,
   output logic                  hit_o
);

   always_comb begin
      data_o = rf_data_i;
      sel_o  = SELW'(sel_rf(NSRC));
      hit_o  = 1'b0;
      // Scan from the oldest source down so the youngest match is the last writer.
      for (int i = NSRC - 1; i >= 0; i--)
         if (src_we_i[i] && src_addr_i[i*AW +: AW] == addr_i) begin
            data_o = src_data_i[i*WIDTH +: WIDTH];
            sel_o  = SELW'(i);
            hit_o  = 1'b1;
         end
      // Register 0 is hardwired zero and never forwarded.
      if (addr_i == '0) begin
         data_o = '0;
         sel_o  = SELW'(sel_rf(NSRC));
         hit_o  = 1'b0;
      end
   end

endmodule

// File: rtl/fwd_operand_reg.sv
// fwd_operand_reg: registered ID/EX operand with forwarding, stall re-snoop, flush and hit counter.
// Ports:
//   clk, rst            - clock and asynchronous active-high reset
//   stall, flush        - hold the operand / insert a bubble (flush wins)
//   in_valid, in_addr   - operand request and its source register address
//   rf_data             - register-file read data for in_addr
//   src_we/addr/data    - packed in-flight forwarding sources, index 0 youngest
//   out_valid/addr/data - registered operand
//   out_sel             - source that supplied out_data, NSRC for register file
//   hit_cnt             - saturating count of forwarded captures
module fwd_operand_reg
   import fwd_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int AW = 5,
   parameter int NSRC = 3,
   parameter int CNTW = 16,
   localparam int SELW = sel_w(NSRC)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  in_valid,
   input  logic [AW-1:0]         in_addr,
   input  logic [WIDTH-1:0]      rf_data,
   input  logic [NSRC-1:0]       src_we,
   input  logic [NSRC*AW-1:0]    src_addr,
   input  logic [NSRC*WIDTH-1:0] src_data,
   output logic                  out_valid,
   output logic [AW-1:0]         out_addr,
   output logic [WIDTH-1:0]      out_data,
   output logic [SELW-1:0]       out_sel,
   output logic [CNTW-1:0]       hit_cnt
);

   localparam logic [SELW-1:0] SEL_RF = SELW'(sel_rf(NSRC));

   logic              valid_q, valid_d;
   logic [AW-1:0]     addr_q, addr_d;
   logic [WIDTH-1:0]  data_q, data_d, c_data, r_data;
   logic [SELW-1:0]   sel_q, sel_d, c_sel, r_sel;
   logic [CNTW-1:0]   cnt_q, cnt_d;
   logic              c_hit, r_hit;

   // Capture path looks up the incoming address.
   fwd_prio_sel #(.WIDTH(WIDTH), .AW(AW), .NSRC(NSRC)) u_cap (
      .addr_i(in_addr), .rf_data_i(rf_data), .src_we_i(src_we), .src_addr_i(src_addr),
      .src_data_i(src_data), .data_o(c_data), .sel_o(c_sel), .hit_o(c_hit)
   );

   // Refresh path re-snoops the held address while stalled; its rf fallback is unused.
   fwd_prio_sel #(.WIDTH(WIDTH), .AW(AW), .NSRC(NSRC)) u_ref (
      .addr_i(addr_q), .rf_data_i(data_q), .src_we_i(src_we), .src_addr_i(src_addr),
      .src_data_i(src_data), .data_o(r_data), .sel_o(r_sel), .hit_o(r_hit)
   );

   always_comb begin
      valid_d = valid_q;
      addr_d  = addr_q;
      data_d  = data_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      if (flush) begin
         valid_d = 1'b0;
         addr_d  = '0;
         data_d  = '0;
         sel_d   = SEL_RF;
      end else if (stall) begin
         data_d = (valid_q && r_hit) ? r_data : data_q;
         sel_d  = (valid_q && r_hit) ? r_sel : sel_q;
      end else begin
         valid_d = in_valid;
         addr_d  = in_addr;
         data_d  = c_data;
         sel_d   = c_sel;
         cnt_d   = (in_valid && c_hit && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         sel_q   <= SEL_RF;
         cnt_q   <= '0;
      end else begin
         valid_q <= valid_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out_valid = valid_q;
   assign out_addr  = addr_q;
   assign out_data  = data_q;
   assign out_sel   = sel_q;
   assign hit_cnt   = cnt_q;

endmodule

// File: tb/tb_fwd_operand_reg.sv
// tb_fwd_operand_reg: directed-vector bench for fwd_operand_reg (default and CNTW=2 instances).
module tb_fwd_operand_reg;

   localparam int WIDTH = 32;
   localparam int AW = 5;
   localparam int NSRC = 3;

   logic                  clk = 1'b0;
   logic                  rst, stall, flush, in_valid;
   logic [AW-1:0]         in_addr;
   logic [WIDTH-1:0]      rf_data;
   logic [NSRC-1:0]       src_we;
   logic [NSRC*AW-1:0]    src_addr;
   logic [NSRC*WIDTH-1:0] src_data;
   logic                  out_valid, out_valid2;
   logic [AW-1:0]         out_addr, out_addr2;
   logic [WIDTH-1:0]      out_data, out_data2;
   logic [1:0]            out_sel, out_sel2;
   logic [15:0]           hit_cnt;
   logic [1:0]            hit_cnt2;

   int n_chk = 0;
   int n_ok = 0;

   always #5 clk = ~clk;

   fwd_operand_reg #(.WIDTH(WIDTH), .AW(AW), .NSRC(NSRC), .CNTW(16)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
      .in_addr(in_addr), .rf_data(rf_data), .src_we(src_we), .src_addr(src_addr),
      .src_data(src_data), .out_valid(out_valid), .out_addr(out_addr),
      .out_data(out_data), .out_sel(out_sel), .hit_cnt(hit_cnt)
   );

   fwd_operand_reg #(.WIDTH(WIDTH), .AW(AW), .NSRC(NSRC), .CNTW(2)) dut2 (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
      .in_addr(in_addr), .rf_data(rf_data), .src_we(src_we), .src_addr(src_addr),
      .src_data(src_data), .out_valid(out_valid2), .out_addr(out_addr2),
      .out_data(out_data2), .out_sel(out_sel2), .hit_cnt(hit_cnt2)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_ok++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic set_src(input int i, input logic we, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
      src_we[i] = we;
      src_addr[i*AW +: AW] = a;
      src_data[i*WIDTH +: WIDTH] = d;
   endtask

   task automatic clr_src();
      src_we = '0;
      src_addr = '0;
      src_data = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic v, input logic [AW-1:0] a,
                            input logic [WIDTH-1:0] d, input logic [1:0] s, input logic [15:0] c);
      check({tag, ".valid"}, 64'(out_valid), 64'(v));
      check({tag, ".addr"}, 64'(out_addr), 64'(a));
      check({tag, ".data"}, 64'(out_data), 64'(d));
      check({tag, ".sel"}, 64'(out_sel), 64'(s));
      check({tag, ".cnt"}, 64'(hit_cnt), 64'(c));
   endtask

   initial begin
      rst = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
      in_addr = '0; rf_data = '0;
      clr_src();
      step();
      step();
      check_out("reset", 1'b0, 5'd0, 32'h0, 2'd3, 16'd0);
      check("reset.cnt2", 64'(hit_cnt2), 64'd0);
      rst = 1'b0;

      // Register-file read, no forwarding.
      in_valid = 1'b1; in_addr = 5'd5; rf_data = 32'h11;
      step();
      check_out("rf_read", 1'b1, 5'd5, 32'h11, 2'd3, 16'd0);

      // Two sources match; lower index wins.
      set_src(1, 1'b1, 5'd5, 32'hAA);
      set_src(2, 1'b1, 5'd5, 32'hBB);
      step();
      check_out("prio", 1'b1, 5'd5, 32'hAA, 2'd1, 16'd1);

      // Address 0 is never forwarded and reads as zero.
      clr_src();
      set_src(0, 1'b1, 5'd0, 32'hFF);
      in_addr = 5'd0; rf_data = 32'h33;
      step();
      check_out("addr0", 1'b1, 5'd0, 32'h0, 2'd3, 16'd1);

      // Invalid capture still takes the select path but does not count.
      set_src(0, 1'b1, 5'd9, 32'h44);
      in_valid = 1'b0; in_addr = 5'd9;
      step();
      check_out("inval", 1'b0, 5'd9, 32'h44, 2'd0, 16'd1);

      // Capture 7 from rf, then stall and re-snoop.
      clr_src();
      in_valid = 1'b1; in_addr = 5'd7; rf_data = 32'h10;
      step();
      check_out("cap7", 1'b1, 5'd7, 32'h10, 2'd3, 16'd1);
      stall = 1'b1; in_addr = 5'd8; rf_data = 32'h99;
      set_src(2, 1'b1, 5'd7, 32'h20);
      step();
      check_out("stall1", 1'b1, 5'd7, 32'h20, 2'd2, 16'd1);
      set_src(0, 1'b1, 5'd7, 32'h30);
      step();
      check_out("stall2", 1'b1, 5'd7, 32'h30, 2'd0, 16'd1);
      clr_src();
      set_src(1, 1'b1, 5'd8, 32'h55);
      step();
      check_out("stall3", 1'b1, 5'd7, 32'h30, 2'd0, 16'd1);

      // Flush overrides stall.
      flush = 1'b1;
      step();
      check_out("flush", 1'b0, 5'd0, 32'h0, 2'd3, 16'd1);
      flush = 1'b0;

      // Re-capture, stall, then asynchronous reset mid-cycle.
      stall = 1'b0; clr_src();
      in_addr = 5'd7; rf_data = 32'h10;
      step();
      check_out("cap7b", 1'b1, 5'd7, 32'h10, 2'd3, 16'd1);
      stall = 1'b1;
      step();
      #2 rst = 1'b1;
      #1;
      check_out("async_rst", 1'b0, 5'd0, 32'h0, 2'd3, 16'd0);
      step();
      rst = 1'b0; stall = 1'b0;

      // Counter saturation: five forwarded captures.
      for (int k = 1; k <= 5; k++) begin
         set_src(0, 1'b1, 5'd3, WIDTH'(k));
         in_valid = 1'b1; in_addr = 5'd3;
         step();
         check($sformatf("sat%0d.cnt16", k), 64'(hit_cnt), 64'(k));
         check($sformatf("sat%0d.cnt2", k), 64'(hit_cnt2), 64'(k > 3 ? 3 : k));
         check($sformatf("sat%0d.data2", k), 64'(out_data2), 64'(k));
      end

      $display("%0d/%0d checks passed", n_ok, n_chk);
      $finish;
   end

endmodule
